// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller.
package seg_scan_ctrl_pkg;

  // Active-low segments: all ones turns every segment and the DP off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Hex nibble to active-low 7-segment pattern, bits 6..0 = g..a.
module hex7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Pure lookup of the glyph for each hex value.
  always_comb begin
    seg_n = 7'h7F;
    case (hex)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl_tick.sv
// Scan sequencer: IDLE/SCAN state, slot cycle counter, digit index,
// frame wrap strobe and registered frame_done pulse.
module scan_tick_gen
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned IDX_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output scan_state_e      state,
  output logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             frame_done
);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_done_q, frame_done_d;

  // State, counter and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next state; a disable in SCAN aborts the frame without a wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (enable) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
          cnt_d = '0;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    frame_done_d = wrap;
  end

  assign state      = state_q;
  assign cnt        = cnt_q;
  assign idx        = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: handshake load, frame-boundary
// display update, guard interval and leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  scan_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              wrap;

  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic                    pend_full_q, pend_full_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;

  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]            nibble;
  logic                  blank_sel;
  logic [6:0]            seg7_n;
  logic                  accept;
  logic                  transfer;
  logic                  lit;

  scan_tick_gen #(
    .NUM_DIGITS (NUM_DIGITS),
    .TICK_DIV   (TICK_DIV),
    .CNT_W      (CNT_W),
    .IDX_W      (IDX_W)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .state      (state),
    .cnt        (cnt),
    .idx        (idx),
    .wrap       (wrap),
    .frame_done (frame_done)
  );

  hex7seg u_dec (
    .hex   (nibble),
    .seg_n (seg7_n)
  );

  assign load_ready = !pend_full_q && !rst;
  assign accept     = load_valid && load_ready;
  // Accept and transfer are mutually exclusive since ready is low while full.
  assign transfer   = pend_full_q && ((state == ST_IDLE) || wrap);

  // Holding registers and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      disp_q      <= '0;
      pend_full_q <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      pend_q      <= pend_d;
      disp_q      <= disp_d;
      pend_full_q <= pend_full_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  // Pending word capture and frame-boundary move into the display word.
  always_comb begin
    pend_d      = pend_q;
    disp_d      = disp_q;
    pend_full_d = pend_full_q;
    if (transfer) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = load_data;
      pend_full_d = 1'b1;
    end
  end

  // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic run;
    run        = 1'b1;
    upper_zero = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      run = run && (disp_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      upper_zero[NUM_DIGITS-1-k] = run;
    end
  end

  // Select the current digit's nibble and its blank condition.
  always_comb begin
    nibble    = '0;
    blank_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble    = disp_q[4*i +: 4];
        blank_sel = (i != 0) && upper_zero[i];
      end
    end
  end

  // Next anode/segment pattern; dark during guard, idle and blanked digits.
  always_comb begin
    lit   = (state == ST_SCAN) && (cnt >= CNT_W'(GUARD)) && !(blank_lz && blank_sel);
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (lit) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx != IDX_W'(i));
      end
      seg_d = {1'b1, seg7_n};
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a frame-position model.
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int T = 4;
  localparam int G = 1;
  localparam int F = N * T;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        blank_lz;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS (N),
    .TICK_DIV   (T),
    .GUARD      (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: whether scanning, position within the frame, and the two words.
  bit          m_scan;
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pf;
  bit          accepted;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_fd;

  function automatic logic [7:0] hexseg(input logic [3:0] h);
    logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[h];
  endfunction

  function automatic bit blanked(input logic [15:0] d, input int k, input bit blz);
    return blz && (k > 0) && ((d >> (4 * k)) == 16'h0);
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    for (int k = 0; k < 4; k++)
      if ($urandom_range(0, 1) == 1) w[4*k +: 4] = 4'h0;
    return w;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int          slot;
    int          ph;
    bit          wr;
    bit          xfer;
    bit          acc;
    logic [15:0] sh;
    if (rst) begin
      m_scan = 0; m_t = 0; m_disp = '0; m_pend = '0; m_pf = 0;
      e_an = 4'hF; e_seg = 8'hFF; e_fd = 1'b0; accepted = 0;
      return;
    end
    slot = m_t / T;
    ph   = m_t % T;
    if (m_scan && ph >= G && !blanked(m_disp, slot, blank_lz)) begin
      sh    = m_disp >> (4 * slot);
      e_an  = 4'hF & ~(4'd1 << slot);
      e_seg = hexseg(sh[3:0]);
    end else begin
      e_an  = 4'hF;
      e_seg = 8'hFF;
    end
    wr   = m_scan && enable && (m_t == F - 1);
    e_fd = wr;
    acc  = load_valid && !m_pf;
    xfer = m_pf && (!m_scan || wr);
    if (xfer) begin m_disp = m_pend; m_pf = 0; end
    if (acc)  begin m_pend = load_data; m_pf = 1; end
    if (m_scan) begin
      if (enable) m_t = (m_t + 1) % F;
      else begin m_scan = 0; m_t = 0; end
    end else if (enable) begin
      m_scan = 1; m_t = 0;
    end
    accepted = acc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("an", {4'h0, an}, {4'h0, e_an});
    check("seg", seg, e_seg);
    check("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
    check("load_ready", {7'h0, load_ready}, {7'h0, (!m_pf && !rst)});
    if (accepted) load_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pos(input int pos);
    int k;
    k = 0;
    while (!(m_scan && m_t == pos) && k < 4 * F) begin
      tick();
      k++;
    end
    n_assert++;
    assert (m_scan && m_t == pos)
    else begin
      n_fail++;
      $error("FAIL wait_pos: observed t=%0d expected t=%0d", m_t, pos);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = '0; blank_lz = 1'b0;
    m_scan = 0; m_t = 0; m_disp = '0; m_pend = '0; m_pf = 0; accepted = 0;
    e_an = 4'hF; e_seg = 8'hFF; e_fd = 1'b0;
    #2;
    check("ready_in_rst", {7'h0, load_ready}, 8'h00);
    run(3);
    rst = 1'b0;
    run(2);

    // Load 12AB while idle, then scan two frames.
    load_data = 16'h12AB; load_valid = 1'b1;
    run(3);
    enable = 1'b1;
    run(2 * F + 2);

    // Mid-frame update followed by a back-pressured word.
    wait_pos(6);
    load_data = 16'h0005; load_valid = 1'b1;
    tick();
    load_data = 16'h3333; load_valid = 1'b1;
    run(3 * F);

    // Leading-zero blanking with 0005 and then 0000.
    blank_lz = 1'b1;
    load_data = 16'h0005; load_valid = 1'b1;
    run(2 * F + 3);
    load_data = 16'h0000; load_valid = 1'b1;
    run(2 * F + 3);
    blank_lz = 1'b0;

    // Disable at slot 2 cycle 2, then re-enable.
    wait_pos(2 * T + 2);
    enable = 1'b0;
    run(4);
    enable = 1'b1;
    run(F + 2);

    // Reset mid-slot with a pending word.
    wait_pos(T + 1);
    load_data = 16'hBEEF; load_valid = 1'b1;
    tick();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(F);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      if (!load_valid && $urandom_range(0, 5) == 0) begin
        load_data  = rand_word();
        load_valid = 1'b1;
      end
      if ($urandom_range(0, 25) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 70) == 0) enable = ~enable;
      rst = ($urandom_range(0, 200) == 0);
      tick();
    end
    rst = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the multi-digit 7-segment display on the multiplier board. It shares one hex-to-7-segment decoder across NUM_DIGITS common-anode digits by rotating the digit select at a fixed refresh rate. It accepts new display values through a valid/ready handshake, applies them only at frame boundaries so digits never tear, inserts an anti-ghosting guard interval, and optionally blanks leading zeros.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
TICK_DIV, 50000, clk cycles per digit slot (>= GUARD+2)
GUARD, 2, cycles at slot start with all anodes off (>= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  1 = scan; 0 = display dark
load_valid  in  1  new display word offered
load_ready  out  1  controller can accept a word
load_data  in  4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit
blank_lz  in  1  1 = blank leading-zero digits
an  out  NUM_DIGITS  digit enables, active-low, one-hot-low or all-ones
seg  out  8  segments, active-low, bit7 = DP (always 1 = off), bits6..0 = g..a
frame_done  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=IDLE, cnt=0, idx=0, disp_reg=0, pend_full=0, an=all 1s, seg=8'hFF, frame_done=0.
- load_ready = !pend_full && !rst. It is combinational.
- When load_valid && load_ready, load_data is captured into pend_reg and pend_full is set.
- FSM IDLE:
  - an=all 1s, seg=8'hFF, cnt=0, idx=0.
  - If pend_full, pend_reg moves to disp_reg and pend_full clears on the next edge.
  - When enable=1, go to SCAN with cnt=0, idx=0.
- FSM SCAN:
  - cnt increments each cycle.
  - When cnt==TICK_DIV-1: cnt goes to 0 and idx increments.
  - When idx==NUM_DIGITS-1 and cnt==TICK_DIV-1: idx wraps to 0, frame_done pulses, and if pend_full then pend_reg moves to disp_reg and pend_full clears.
- enable=0 in SCAN: next state is IDLE, cnt and idx are cleared, frame_done does not pulse, pend_reg is retained.
- Frame-boundary transfer and an accept can never occur in the same cycle, because ready=0 while pend_full.
- A word accepted in the wrap cycle itself is held until the next wrap.
- Digit blank rule: digit idx is blanked if blank_lz=1, idx>0, and every nibble idx..NUM_DIGITS-1 of disp_reg is 0. Digit 0 is never blanked.
- Output registers (an, seg), computed each cycle from the current state/cnt/idx:
  - SCAN with cnt>=GUARD and the digit not blanked: an bit idx=0 (others 1); seg = decoder(nibble idx of disp_reg).
  - Otherwise: an=all 1s, seg=8'hFF.
  - Latency: outputs lag cnt/idx by exactly one cycle.
- frame_done is registered and asserted in the cycle after the wrap edge.
- rst mid-frame or mid-handshake: everything returns to reset values on that edge; pending data is lost.
- Frame period = NUM_DIGITS*TICK_DIV cycles. Each digit is lit for TICK_DIV-GUARD cycles per frame.

Decomposition:
- Shared package holds: SEG_BLANK=8'hFF, and the ST_IDLE/ST_SCAN state encoding.
- Sub-module scan_tick_gen (cnt/idx counter, wrap, frame_done) is natural.
- The codebase's existing hex-to-7-segment decoder is instantiated once and fed the selected nibble. It is the shared resource being scheduled.
- Top-level logic: handshake, pending/display registers, blank logic, output registers.

Test Plan:
(Bench: NUM_DIGITS=4, TICK_DIV=4, GUARD=1.)
- Reset/idle:
  - Stimulus: rst=1 for 3 cycles, enable=0.
  - Response: an=4'b1111, seg=8'hFF, load_ready=0 during rst and 1 after, frame_done=0.
- Scan order:
  - Stimulus: in IDLE, load 16'h12AB, then enable=1.
  - Response: disp_reg=12AB before scan starts.
  - Each 4-cycle slot shows 1 dark cycle then 3 lit cycles: an=1110/seg=~b (8'h83), an=1101/seg=~A (8'h88), an=1011/seg=~2 (8'hA4), an=0111/seg=~1 (8'hF9).
  - frame_done pulses every 16 cycles.
- Tear-free update:
  - Stimulus: in SCAN, load 16'h0005 mid-frame.
  - Response: load_ready drops, remaining digits still show 12AB, new value appears from digit 0 of the next frame, load_ready returns to 1 after the wrap.
- Backpressure:
  - Stimulus: hold load_valid with 16'h3333 while pend_full.
  - Response: not accepted until the cycle after transfer. Exactly one capture occurs; disp_reg becomes 3333 one frame later.
- Leading-zero blanking:
  - Stimulus: disp_reg=16'h0005, blank_lz=1.
  - Response: only digit 0 lit (seg=8'h92); digits 1–3 keep an=1 all slot.
  - Stimulus: disp_reg=0, blank_lz=1.
  - Response: digit 0 shows 8'hC0.
- Disable/reset mid-frame:
  - Stimulus: enable=0 at slot 2 cycle 2.
  - Response: next cycle IDLE, outputs dark one cycle later, no frame_done.
  - Stimulus: re-enable.
  - Response: restarts at idx 0.
  - Stimulus: rst mid-slot.
  - Response: all outputs at reset values next cycle.
